// File: rtl/ppm_sym_decoder_if.sv
// Line-side and decoded-symbol signals of the PPM symbol decoder.
// The slave modport is the decoder side; the master modport drives the line and consumes results.
interface ppm_sym_decoder_if;
   logic       Din;
   logic       eof_rcv_in;
   logic [7:0] data_out;
   logic       data_valid;
   logic       frame_active;
   logic       sym_err;
   logic       frame_done;

   modport master (
      output Din, eof_rcv_in,
      input  data_out, data_valid, frame_active, sym_err, frame_done
   );

   modport slave (
      input  Din, eof_rcv_in,
      output data_out, data_valid, frame_active, sym_err, frame_done
   );
endinterface

// File: rtl/ppm_sym_decoder.sv
// 4-PPM symbol decoder: one active-low pulse per 4-slot window carries 2 bits,
// four symbols assemble a byte LSB-first; frames start on a pulse and end on eof.
module ppm_sym_decoder #(
   parameter int SLOT_CYC = 8
) (
   input logic               clk16,
   input logic               rst,
   ppm_sym_decoder_if.slave  bus
);
   localparam int SW = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
   localparam logic [SW-1:0] SUB_LAST = SW'(SLOT_CYC - 1);

   typedef enum logic {S_IDLE, S_RX} state_t;

   state_t        r_state, w_state_nxt;
   logic          r_sync1, r_sync2, r_sync3;
   // cyc_cnt is kept as {slot, sub-slot} so the symbol value needs no divider
   logic [SW-1:0] r_sub, w_sub_nxt;
   logic [1:0]    r_slot, w_slot_nxt;
   logic [1:0]    r_sym_cnt, w_sym_cnt_nxt;
   logic          r_have, w_have_nxt;
   logic [1:0]    r_sym, w_sym_nxt;
   logic [7:0]    r_byte, w_byte_nxt;
   logic [7:0]    r_data, w_data_nxt;
   logic          r_dv, w_dv_nxt;
   logic          r_err, w_err_nxt;
   logic          r_done, w_done_nxt;

   logic          w_fall;
   logic          w_wrap;
   logic [1:0]    w_sym_in;
   logic [7:0]    w_byte_shift;

   // A pulse coinciding with eof is dropped, in RX and in IDLE alike
   assign w_fall       = r_sync3 & ~r_sync2 & ~bus.eof_rcv_in;
   assign w_wrap       = (r_slot == 2'd3) && (r_sub == SUB_LAST);
   assign w_sym_in     = r_have ? r_sym : r_slot;
   assign w_byte_shift = {w_sym_in, r_byte[7:2]};

   always_comb begin
      w_state_nxt   = r_state;
      w_sub_nxt     = r_sub;
      w_slot_nxt    = r_slot;
      w_sym_cnt_nxt = r_sym_cnt;
      w_have_nxt    = r_have;
      w_sym_nxt     = r_sym;
      w_byte_nxt    = r_byte;
      w_data_nxt    = r_data;
      w_dv_nxt      = 1'b0;
      w_err_nxt     = 1'b0;
      w_done_nxt    = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_sub_nxt     = '0;
            w_slot_nxt    = 2'd0;
            w_sym_cnt_nxt = 2'd0;
            w_have_nxt    = 1'b0;
            w_byte_nxt    = 8'h00;
            if (w_fall) w_state_nxt = S_RX;
         end
         S_RX: begin
            if (r_sub == SUB_LAST) begin
               w_sub_nxt  = '0;
               w_slot_nxt = r_slot + 2'd1;
            end else begin
               w_sub_nxt  = r_sub + 1'b1;
            end
            if (w_fall && r_have) begin
               w_err_nxt   = 1'b1;
               w_state_nxt = S_IDLE;
            end else begin
               if (w_fall) begin
                  w_have_nxt = 1'b1;
                  w_sym_nxt  = r_slot;
               end
               if (w_wrap) begin
                  w_have_nxt = 1'b0;
                  if (!(r_have || w_fall)) begin
                     w_err_nxt   = 1'b1;
                     w_state_nxt = S_IDLE;
                  end else begin
                     w_byte_nxt    = w_byte_shift;
                     w_sym_cnt_nxt = r_sym_cnt + 2'd1;
                     if (r_sym_cnt == 2'd3) begin
                        w_data_nxt = w_byte_shift;
                        w_dv_nxt   = 1'b1;
                     end
                  end
               end
               // eof after a closing window sees the fresh, still-empty window
               if (bus.eof_rcv_in) begin
                  w_done_nxt  = 1'b1;
                  w_state_nxt = S_IDLE;
                  if (w_wrap) w_err_nxt = w_err_nxt | (w_sym_cnt_nxt != 2'd0);
                  else        w_err_nxt = (r_sym_cnt != 2'd0) | r_have;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk16) begin
      if (rst) begin
         r_sync1   <= 1'b1;
         r_sync2   <= 1'b1;
         r_sync3   <= 1'b1;
         r_state   <= S_IDLE;
         r_sub     <= '0;
         r_slot    <= 2'd0;
         r_sym_cnt <= 2'd0;
         r_have    <= 1'b0;
         r_sym     <= 2'd0;
         r_byte    <= 8'h00;
         r_data    <= 8'h00;
         r_dv      <= 1'b0;
         r_err     <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_sync1   <= bus.Din;
         r_sync2   <= r_sync1;
         r_sync3   <= r_sync2;
         r_state   <= w_state_nxt;
         r_sub     <= w_sub_nxt;
         r_slot    <= w_slot_nxt;
         r_sym_cnt <= w_sym_cnt_nxt;
         r_have    <= w_have_nxt;
         r_sym     <= w_sym_nxt;
         r_byte    <= w_byte_nxt;
         r_data    <= w_data_nxt;
         r_dv      <= w_dv_nxt;
         r_err     <= w_err_nxt;
         r_done    <= w_done_nxt;
      end
   end

   assign bus.data_out     = r_data;
   assign bus.data_valid   = r_dv;
   assign bus.frame_active = (r_state == S_RX);
   assign bus.sym_err      = r_err;
   assign bus.frame_done   = r_done;
endmodule

// File: tb/tb_ppm_sym_decoder.sv
// Directed bench for ppm_sym_decoder (SLOT_CYC=8): pulses placed mid-slot, strobe cycles
// recorded relative to the SOF pulse and compared with hand-derived cycle numbers.
module tb_ppm_sym_decoder;
   logic clk16 = 1'b0;
   logic rst;
   ppm_sym_decoder_if bus ();

   ppm_sym_decoder #(.SLOT_CYC(8)) dut (
      .clk16 (clk16),
      .rst   (rst),
      .bus   (bus)
   );

   always #5 clk16 = ~clk16;

   int n_pass = 0;
   int n_tot  = 0;

   int         pq[$];
   int         dv_cnt, er_cnt, fd_cnt, er_n, fd_n;
   int         dv_n[4];
   logic [7:0] dv_d[4];
   logic       fa0, fa1;

   task automatic tick();
      @(posedge clk16);
      #1;
   endtask

   // SOF is sampled at edge S; iteration n drives the line then observes edge S+n+1.
   // A pulse driven at iteration n lands at window cycle n; eof at iteration n lands at cycle n-2.
   task automatic run_seq(input int ncyc, input int eof_n);
      dv_cnt = 0; er_cnt = 0; fd_cnt = 0; er_n = -1; fd_n = -1;
      bus.Din = 1'b0;
      tick();
      bus.Din = 1'b1;
      for (int n = 0; n < ncyc; n++) begin
         bus.Din = 1'b1;
         foreach (pq[i]) if (pq[i] == n) bus.Din = 1'b0;
         bus.eof_rcv_in = (n == eof_n);
         tick();
         bus.eof_rcv_in = 1'b0;
         if (n == 0) fa0 = bus.frame_active;
         if (n == 1) fa1 = bus.frame_active;
         if (bus.data_valid) begin
            if (dv_cnt < 4) begin
               dv_n[dv_cnt] = n;
               dv_d[dv_cnt] = bus.data_out;
            end
            dv_cnt++;
         end
         if (bus.sym_err)    begin er_cnt++; er_n = n; end
         if (bus.frame_done) begin fd_cnt++; fd_n = n; end
      end
      bus.Din = 1'b1;
   endtask

   task automatic idle(input int k);
      for (int i = 0; i < k; i++) tick();
   endtask

   task automatic test_reset();
      rst = 1'b1; bus.Din = 1'b1; bus.eof_rcv_in = 1'b0;
      idle(3);
      n_tot++;
      if (bus.data_out !== 8'h00) $display("FAIL reset_data_out got=%h exp=00", bus.data_out);
      else n_pass++;
      n_tot++;
      if ({bus.data_valid, bus.frame_active, bus.sym_err, bus.frame_done} !== 4'b0000)
         $display("FAIL reset_flags got=%b exp=0000",
                  {bus.data_valid, bus.frame_active, bus.sym_err, bus.frame_done});
      else n_pass++;
      rst = 1'b0;
      idle(4);
   endtask

   task automatic test_single_byte();
      pq = '{4, 44, 84, 124};
      run_seq(150, 140);
      n_tot++; if ({fa0, fa1} !== 2'b01) $display("FAIL sof_latency got=%b exp=01", {fa0, fa1}); else n_pass++;
      n_tot++; if (dv_cnt !== 1) $display("FAIL e4_dv_count got=%0d exp=1", dv_cnt); else n_pass++;
      n_tot++; if (dv_n[0] !== 129) $display("FAIL e4_dv_cycle got=%0d exp=129", dv_n[0]); else n_pass++;
      n_tot++; if (dv_d[0] !== 8'hE4) $display("FAIL e4_data got=%h exp=e4", dv_d[0]); else n_pass++;
      n_tot++; if (fd_n !== 140 || fd_cnt !== 1) $display("FAIL e4_frame_done got=%0d/%0d exp=140/1", fd_n, fd_cnt); else n_pass++;
      n_tot++; if (er_cnt !== 0) $display("FAIL e4_no_err got=%0d exp=0", er_cnt); else n_pass++;
      n_tot++; if (bus.frame_active !== 1'b0) $display("FAIL e4_idle got=%b exp=0", bus.frame_active); else n_pass++;
      n_tot++; if (bus.data_out !== 8'hE4) $display("FAIL e4_hold got=%h exp=e4", bus.data_out); else n_pass++;
      idle(4);
   endtask

   task automatic test_rst_mid();
      pq = '{4, 36};
      run_seq(80, -1);
      n_tot++; if (bus.frame_active !== 1'b1 || er_cnt !== 0) $display("FAIL rst_pre_active got=%b/%0d exp=1/0", bus.frame_active, er_cnt); else n_pass++;
      rst = 1'b1;
      tick();
      n_tot++;
      if ({bus.data_out, bus.data_valid, bus.frame_active, bus.sym_err, bus.frame_done} !== 12'h000)
         $display("FAIL rst_mid_outputs got=%h exp=000",
                  {bus.data_out, bus.data_valid, bus.frame_active, bus.sym_err, bus.frame_done});
      else n_pass++;
      rst = 1'b0;
      idle(3);
      pq = '{20, 36, 92, 108};
      run_seq(140, 135);
      n_tot++; if (dv_cnt !== 1 || dv_d[0] !== 8'h72) $display("FAIL rst_redo_data got=%0d/%h exp=1/72", dv_cnt, dv_d[0]); else n_pass++;
      n_tot++; if (dv_n[0] !== 129 || fd_n !== 135 || er_cnt !== 0) $display("FAIL rst_redo_timing got=%0d/%0d/%0d exp=129/135/0", dv_n[0], fd_n, er_cnt); else n_pass++;
      idle(4);
   endtask

   task automatic test_back_to_back();
      pq = '{28, 60, 92, 124, 132, 164, 196, 228};
      run_seq(280, 270);
      n_tot++; if (dv_cnt !== 2) $display("FAIL b2b_dv_count got=%0d exp=2", dv_cnt); else n_pass++;
      n_tot++; if (dv_d[0] !== 8'hFF || dv_d[1] !== 8'h00) $display("FAIL b2b_data got=%h,%h exp=ff,00", dv_d[0], dv_d[1]); else n_pass++;
      n_tot++; if (dv_n[0] !== 129 || dv_n[1] !== 257) $display("FAIL b2b_cycles got=%0d,%0d exp=129,257", dv_n[0], dv_n[1]); else n_pass++;
      n_tot++; if (fd_n !== 270 || er_cnt !== 0) $display("FAIL b2b_end got=%0d/%0d exp=270/0", fd_n, er_cnt); else n_pass++;
      idle(4);
   endtask

   task automatic test_double_pulse();
      pq = '{12, 20};
      run_seq(60, -1);
      n_tot++; if (er_cnt !== 1 || er_n !== 22) $display("FAIL dbl_err got=%0d@%0d exp=1@22", er_cnt, er_n); else n_pass++;
      n_tot++; if (dv_cnt !== 0 || fd_cnt !== 0 || bus.frame_active !== 1'b0) $display("FAIL dbl_state got=%0d/%0d/%b exp=0/0/0", dv_cnt, fd_cnt, bus.frame_active); else n_pass++;
      idle(4);
   endtask

   task automatic test_empty_window();
      pq = '{12, 44};
      run_seq(110, -1);
      n_tot++; if (er_cnt !== 1 || er_n !== 97) $display("FAIL empty_err got=%0d@%0d exp=1@97", er_cnt, er_n); else n_pass++;
      n_tot++; if (dv_cnt !== 0 || bus.frame_active !== 1'b0) $display("FAIL empty_state got=%0d/%b exp=0/0", dv_cnt, bus.frame_active); else n_pass++;
      idle(4);
   endtask

   task automatic test_eof_early();
      pq = '{4, 36};
      run_seq(90, 80);
      n_tot++; if (fd_cnt !== 1 || fd_n !== 80) $display("FAIL early_done got=%0d@%0d exp=1@80", fd_cnt, fd_n); else n_pass++;
      n_tot++; if (er_cnt !== 1 || er_n !== 80) $display("FAIL early_err got=%0d@%0d exp=1@80", er_cnt, er_n); else n_pass++;
      n_tot++; if (dv_cnt !== 0 || bus.frame_active !== 1'b0) $display("FAIL early_state got=%0d/%b exp=0/0", dv_cnt, bus.frame_active); else n_pass++;
      idle(4);
   endtask

   task automatic test_eof_at_close();
      pq = '{4, 36, 68, 108};
      run_seq(140, 129);
      n_tot++; if (dv_cnt !== 1 || dv_n[0] !== 129 || dv_d[0] !== 8'h40) $display("FAIL close_dv got=%0d@%0d=%h exp=1@129=40", dv_cnt, dv_n[0], dv_d[0]); else n_pass++;
      n_tot++; if (fd_n !== 129 || er_cnt !== 0) $display("FAIL close_done got=%0d/%0d exp=129/0", fd_n, er_cnt); else n_pass++;
      idle(4);
   endtask

   task automatic test_eof_idle();
      int strobes;
      strobes = 0;
      bus.eof_rcv_in = 1'b1;
      tick();
      bus.eof_rcv_in = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         strobes += int'(bus.data_valid) + int'(bus.sym_err) + int'(bus.frame_done) + int'(bus.frame_active);
      end
      n_tot++; if (strobes !== 0) $display("FAIL idle_eof got=%0d exp=0", strobes); else n_pass++;
      // line pulse whose detection coincides with eof must not open a frame
      bus.Din = 1'b0;
      tick();
      bus.Din = 1'b1;
      tick();
      bus.eof_rcv_in = 1'b1;
      tick();
      bus.eof_rcv_in = 1'b0;
      strobes = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         strobes += int'(bus.frame_active) + int'(bus.frame_done) + int'(bus.sym_err);
      end
      n_tot++; if (strobes !== 0) $display("FAIL fall_with_eof got=%0d exp=0", strobes); else n_pass++;
      n_tot++; if (bus.data_out !== 8'h40) $display("FAIL idle_hold got=%h exp=40", bus.data_out); else n_pass++;
   endtask

   initial begin
      rst = 1'b1;
      bus.Din = 1'b1;
      bus.eof_rcv_in = 1'b0;
      test_reset();
      test_single_byte();
      test_rst_mid();
      test_back_to_back();
      test_double_pulse();
      test_empty_window();
      test_eof_early();
      test_eof_at_close();
      test_eof_idle();
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
